// File: rtl/rand_req_collector.sv
// Round-robin front end for the TRNG rand_req/rand_byte port: grants one of N_CH
// requesters, assembles the returned byte stream into a word, and reports done or error.
package rand_req_pkg;
  typedef enum logic [2:0] {
    RNG_NONE  = 3'd0,
    RDRAND_16 = 3'd1,
    RDRAND_32 = 3'd2,
    RDRAND_64 = 3'd3,
    RDSEED_16 = 3'd4,
    RDSEED_32 = 3'd5,
    RDSEED_64 = 3'd6
  } rand_req_t;
endpackage

module rand_req_collector
  import rand_req_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int MAX_BYTES  = 8,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 1,
  parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                       ic_clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            ch_req,
  input  rand_req_t [N_CH-1:0]       ch_type,
  input  logic [N_CH-1:0][LEN_W-1:0] ch_len,
  output logic [N_CH-1:0]            ch_grant,
  output logic [N_CH-1:0]            ch_done,
  output logic [N_CH-1:0]            ch_err,
  output logic [8*MAX_BYTES-1:0]     ch_data,
  output logic                       rand_req,
  output rand_req_t                  rand_req_type,
  input  logic [7:0]                 rand_byte,
  input  logic                       rand_valid,
  output logic                       busy
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int DW    = 8 * MAX_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_idx;
  rand_req_t         r_type;
  logic [LEN_W-1:0]  r_len;
  logic              r_bad;
  logic [LEN_W-1:0]  r_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic [GAP_W-1:0]  r_gap;
  logic [DW-1:0]     r_buf;
  logic [DW-1:0]     r_data;
  logic [N_CH-1:0]   r_grant;
  logic [N_CH-1:0]   r_done;
  logic [N_CH-1:0]   r_err;
  logic              r_rand_req;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_cand;
  logic [IDX_W-1:0]  w_ptr_next;
  logic [LEN_W-1:0]  w_len;
  logic              w_len_bad;
  logic [N_CH-1:0]   w_win_oh;
  logic [N_CH-1:0]   w_idx_oh;
  logic [LEN_W-1:0]  w_cnt_inc;
  logic [DW-1:0]     w_buf_next;
  logic [DW-1:0]     w_mask;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % N_CH);
      if (!w_found && ch_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_ptr_next = IDX_W'((int'(w_win) + 1) % N_CH);
  assign w_len      = ch_len[w_win];
  assign w_len_bad  = (w_len == '0) || (int'(w_len) > MAX_BYTES);
  assign w_win_oh   = N_CH'(1) << w_win;
  assign w_idx_oh   = N_CH'(1) << r_idx;
  assign w_cnt_inc  = r_cnt + LEN_W'(1);

  // Byte lanes: insert the incoming byte, and mask lanes beyond the requested length.
  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
    assign w_buf_next[8*gi +: 8] = (r_cnt == LEN_W'(gi)) ? rand_byte : r_buf[8*gi +: 8];
    assign w_mask[8*gi +: 8]     = (LEN_W'(gi) < r_len) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge ic_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_type     <= RNG_NONE;
      r_len      <= '0;
      r_bad      <= 1'b0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_gap      <= '0;
      r_buf      <= '0;
      r_data     <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_rand_req <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx   <= w_win;
            r_type  <= ch_type[w_win];
            r_len   <= w_len;
            r_bad   <= w_len_bad;
            r_ptr   <= w_ptr_next;
            r_grant <= w_win_oh;
            r_cnt   <= '0;
            r_timer <= '0;
            r_gap   <= '0;
            r_state <= w_len_bad ? S_GAP : S_REQ;
          end
        end
        S_REQ: begin
          // The first REQ cycle only raises rand_req, so it lags the grant by one cycle.
          if (!r_rand_req) begin
            r_rand_req <= 1'b1;
          end else if (rand_valid) begin
            r_buf   <= w_buf_next;
            r_cnt   <= w_cnt_inc;
            r_timer <= '0;
            if (w_cnt_inc == r_len) begin
              r_rand_req <= 1'b0;
              r_data     <= w_buf_next & w_mask;
              r_done     <= w_idx_oh;
              r_state    <= S_GAP;
            end
          end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            r_rand_req <= 1'b0;
            r_err      <= w_idx_oh;
            r_state    <= S_GAP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_GAP: begin
          r_cnt   <= '0;
          r_timer <= '0;
          r_bad   <= 1'b0;
          if (r_bad) r_err <= w_idx_oh;
          if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_gap   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_grant      = r_grant;
  assign ch_done       = r_done;
  assign ch_err        = r_err;
  assign ch_data       = r_data;
  assign rand_req      = r_rand_req;
  assign rand_req_type = r_type;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_rand_req_collector.sv
// Self-checking bench for rand_req_collector: directed and randomized transactions
// compared against a round-robin / byte-assembly reference model.
module tb_rand_req_collector;
  import rand_req_pkg::*;

  localparam int N_CH    = 4;
  localparam int MAXB    = 8;
  localparam int TIMEOUT = 1024;
  localparam int GAP     = 1;
  localparam int LEN_W   = 4;

  logic                       ic_clk = 1'b0;
  logic                       rst_n;
  logic [N_CH-1:0]            ch_req;
  rand_req_t [N_CH-1:0]       ch_type;
  logic [N_CH-1:0][LEN_W-1:0] ch_len;
  logic [N_CH-1:0]            ch_grant, ch_done, ch_err;
  logic [8*MAXB-1:0]          ch_data;
  logic                       rand_req;
  rand_req_t                  rand_req_type;
  logic [7:0]                 rand_byte;
  logic                       rand_valid;
  logic                       busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  int ptr_m    = 0;
  logic [63:0] data_m = '0;

  rand_req_collector #(
    .N_CH(N_CH), .MAX_BYTES(MAXB), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP), .LEN_W(LEN_W)
  ) dut (
    .ic_clk(ic_clk), .rst_n(rst_n), .ch_req(ch_req), .ch_type(ch_type), .ch_len(ch_len),
    .ch_grant(ch_grant), .ch_done(ch_done), .ch_err(ch_err), .ch_data(ch_data),
    .rand_req(rand_req), .rand_req_type(rand_req_type), .rand_byte(rand_byte),
    .rand_valid(rand_valid), .busy(busy)
  );

  always #5 ic_clk = ~ic_clk;
  always @(posedge ic_clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer; pointer moves past it.
  function automatic int model_pick(input logic [N_CH-1:0] req);
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (ptr_m + k) % N_CH;
      if (req[c]) begin
        ptr_m = (c + 1) % N_CH;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic wait_grant(input int w, output bit ok, output int gcyc);
    int n;
    n = 0;
    @(negedge ic_clk);
    while (ch_grant == '0 && n < 20) begin
      @(negedge ic_clk);
      n++;
    end
    ok   = (ch_grant != '0);
    gcyc = cyc_cnt;
    chk("grant_onehot", ch_grant, 64'(1) << w);
    chk("busy_at_grant", busy, 1);
    chk("excl_at_grant", {ch_done, ch_err}, 0);
  endtask

  // fixed_byte: -1 random bytes, -2 bytes 1,2,3..., otherwise that constant.
  task automatic run_txn(input int stall, input int fixed_byte, input bit drop, output int gcyc);
    int w, len, b;
    bit ok;
    logic [63:0] acc;
    w   = model_pick(ch_req);
    len = int'(ch_len[w]);
    wait_grant(w, ok, gcyc);
    if (!ok) return;
    if (drop) ch_req[w] = 1'b0;
    if (len == 0 || len > MAXB) begin
      @(negedge ic_clk);
      chk("badlen_err", ch_err, 64'(1) << w);
      chk("badlen_no_req", rand_req, 0);
      chk("badlen_data_held", ch_data, data_m);
      return;
    end
    @(negedge ic_clk);
    chk("rand_req_rise", rand_req, 1);
    chk("rand_req_type", rand_req_type, ch_type[w]);
    acc = '0;
    for (int i = 0; i < len; i++) begin
      repeat (stall) @(negedge ic_clk);
      if (fixed_byte == -1) b = int'($urandom_range(0, 255));
      else if (fixed_byte == -2) b = i + 1;
      else b = fixed_byte;
      acc[8*i +: 8] = 8'(b);
      rand_valid = 1'b1;
      rand_byte  = 8'(b);
      @(negedge ic_clk);
      rand_valid = 1'b0;
    end
    chk("done_pulse", ch_done, 64'(1) << w);
    chk("done_data", ch_data, acc);
    chk("done_req_low", rand_req, 0);
    chk("done_no_err", ch_err, 0);
    if (stall == 0) chk("grant_to_done", 64'(cyc_cnt - gcyc), 64'(len + 1));
    data_m = acc;
  endtask

  initial begin
    int g, gp, w;
    bit ok;
    rst_n = 1'b0; ch_req = '0; ch_len = '0; rand_byte = '0; rand_valid = 1'b0;
    for (int i = 0; i < N_CH; i++) ch_type[i] = RDSEED_64;
    repeat (3) @(negedge ic_clk);
    chk("rst_outputs", {ch_grant, ch_done, ch_err, rand_req, busy}, 0);
    chk("rst_data", ch_data, 0);
    chk("rst_type", rand_req_type, 0);
    rst_n = 1'b1;
    @(negedge ic_clk);
    chk("idle_busy", busy, 0);

    // Full-width word, bytes 01..08.
    ch_req = 4'b0001; ch_len[0] = 4'd8; ch_type[0] = RDSEED_64;
    run_txn(0, -2, 1, g);
    chk("t1_word", ch_data, 64'h0807060504030201);

    // Stray rand_valid in GAP and IDLE must be ignored.
    rand_valid = 1'b1; rand_byte = 8'hAA;
    @(negedge ic_clk);
    chk("done_single", ch_done, 0);
    @(negedge ic_clk);
    rand_valid = 1'b0;
    chk("stray_idle", busy, 0);
    chk("stray_data", ch_data, data_m);
    ch_req = 4'b1000; ch_len[3] = 4'd1; ch_type[3] = RDRAND_16;
    run_txn(0, 8'h5A, 1, g);
    chk("t5_word", ch_data, 64'h5A);

    // All four request together, then ch1 and ch3.
    ch_req = 4'b1111;
    for (int i = 0; i < N_CH; i++) begin
      ch_len[i] = 4'd2; ch_type[i] = rand_req_t'($urandom_range(1, 6));
    end
    for (int i = 0; i < N_CH; i++) begin
      gp = g;
      run_txn(0, -1, 1, g);
      if (i > 0) chk("b2b_spacing", 64'(g - gp), 64'(2 + 2 + GAP));
    end
    ch_req = 4'b1010;
    run_txn(0, -1, 1, g);
    run_txn(0, -1, 1, g);

    // Stall just under the timeout between bytes.
    ch_req = 4'b0001; ch_len[0] = 4'd3;
    run_txn(TIMEOUT - 1, -1, 1, g);

    // Stall of exactly the timeout after one byte.
    ch_req = 4'b0001; ch_len[0] = 4'd3;
    w = model_pick(ch_req);
    wait_grant(w, ok, g);
    ch_req = '0;
    @(negedge ic_clk);
    rand_valid = 1'b1; rand_byte = 8'h77;
    @(negedge ic_clk);
    rand_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge ic_clk);
    chk("to_not_yet", ch_err, 0);
    chk("to_req_held", rand_req, 1);
    @(negedge ic_clk);
    chk("to_err", ch_err, 64'(1) << w);
    chk("to_req_low", rand_req, 0);
    chk("to_data_held", ch_data, data_m);
    chk("to_no_done", ch_done, 0);

    // Illegal lengths.
    ch_req = 4'b0100; ch_len[2] = 4'd0;
    run_txn(0, -1, 1, g);
    ch_req = 4'b0100; ch_len[2] = 4'(MAXB + 1);
    run_txn(0, -1, 1, g);

    // Randomized mix of channels, lengths, types and stalls.
    for (int t = 0; t < 12; t++) begin
      ch_req = 4'($urandom_range(1, 15));
      for (int i = 0; i < N_CH; i++) begin
        ch_len[i]  = 4'($urandom_range(0, MAXB + 1));
        ch_type[i] = rand_req_t'($urandom_range(1, 6));
      end
      run_txn(int'($urandom_range(0, 3)), -1, 1, g);
    end
    ch_req = '0;

    // Reset in the middle of a transaction.
    repeat (3) @(negedge ic_clk);
    ch_req = 4'b0010; ch_len[1] = 4'd8;
    w = model_pick(ch_req);
    wait_grant(w, ok, g);
    ch_req = '0;
    @(negedge ic_clk);
    for (int i = 0; i < 3; i++) begin
      rand_valid = 1'b1; rand_byte = 8'(i + 16);
      @(negedge ic_clk);
    end
    rand_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", rand_req, 0);
    chk("midrst_flags", {ch_grant, ch_done, ch_err, busy}, 0);
    chk("midrst_data", ch_data, 0);
    chk("midrst_type", rand_req_type, 0);
    ptr_m  = 0;
    data_m = '0;
    @(negedge ic_clk);
    rst_n = 1'b1;
    ch_req = 4'b0100; ch_len[2] = 4'd8;
    run_txn(0, -1, 1, g);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
